// File: rtl/flash_loader_multi.sv
// rtl/flash_loader_multi.sv - multi-slot SPI flash loader; define LOADER_FAST_READ_EN for 0x0B fast read with dummy byte
module flash_loader_multi #(
  parameter int                ADDR_W     = 22,
  parameter int                INDEX_W    = 4,
  parameter int                SLOT_SHIFT = 18,
  parameter logic [23:0]       BASE_ADDR  = 24'h400000,
  parameter logic [ADDR_W-1:0] DEF_LEN    = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reload,
  input  logic [INDEX_W-1:0] index,
  input  logic [ADDR_W-1:0]  load_len,
  output logic               flash_csn,
  output logic               flash_sck,
  output logic               flash_mosi,
  input  logic               flash_miso,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [7:0]         load_write_data,
  output logic               data_valid,
  input  logic               load_ready,
  output logic               load_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_GAP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_DONE
  } state_t;

`ifdef LOADER_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif

  state_t              r_state, w_state;
  logic                r_csn, w_csn;
  logic                r_sck, w_sck;
  logic [31:0]         r_tx, w_tx;
  logic [7:0]          r_rx, w_rx;
  logic [4:0]          r_cnt, w_cnt;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [7:0]          r_wdata, w_wdata;
  logic                r_valid, w_valid;
  logic                r_done, w_done;
  logic [INDEX_W-1:0]  r_index, w_index;
  logic [ADDR_W-1:0]   r_len, w_len;

  logic [23:0]         w_flash_addr;
  logic [4:0]          w_phase_last;
  state_t              w_phase_next;
  logic                w_last_byte;

  assign w_flash_addr = BASE_ADDR + (24'(r_index) << SLOT_SHIFT);
  assign w_phase_last = (r_state == S_ADDR) ? 5'd23 : 5'd7;
  assign w_last_byte  = (r_addr == r_len - ADDR_W'(1));

  always_comb begin
    w_phase_next = S_DATA;
    if (r_state == S_CMD) begin
      w_phase_next = S_ADDR;
    end else if (r_state == S_ADDR) begin
`ifdef LOADER_FAST_READ_EN
      w_phase_next = S_DUMMY;
`else
      w_phase_next = S_DATA;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_csn   = r_csn;
    w_sck   = r_sck;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_valid = r_valid;
    w_done  = r_done;
    w_index = r_index;
    w_len   = r_len;
    if (reload) begin
      w_state = S_GAP;
      w_csn   = 1'b1;
      w_sck   = 1'b0;
      w_tx    = '0;
      w_cnt   = '0;
      w_addr  = '0;
      w_valid = 1'b0;
      w_done  = 1'b0;
      w_index = index;
      w_len   = load_len;
    end else begin
      case (r_state)
        S_GAP: begin
          if (r_cnt == 5'd1) begin
            w_csn   = 1'b0;
            w_tx    = {OPCODE, w_flash_addr};
            w_cnt   = '0;
            w_state = S_CMD;
          end else begin
            w_cnt = r_cnt + 5'd1;
          end
        end
        // Outgoing bits shift on the falling sck edge so mosi is stable at the rise.
        S_CMD, S_ADDR, S_DUMMY: begin
          if (!r_sck) begin
            w_sck = 1'b1;
          end else begin
            w_sck = 1'b0;
            w_tx  = {r_tx[30:0], 1'b0};
            w_cnt = r_cnt + 5'd1;
            if (r_cnt == w_phase_last) begin
              w_cnt   = '0;
              w_state = w_phase_next;
            end
          end
        end
        S_DATA: begin
          if (!r_sck) begin
            w_sck = 1'b1;
            w_rx  = {r_rx[6:0], flash_miso};
            w_cnt = r_cnt + 5'd1;
          end else begin
            w_sck = 1'b0;
            if (r_cnt == 5'd8) begin
              w_wdata = r_rx;
              w_valid = 1'b1;
              w_cnt   = '0;
              w_state = S_HOLD;
            end
          end
        end
        // The next byte's MSB is already on miso, so acceptance doubles as its first rise.
        S_HOLD: begin
          if (load_ready) begin
            w_valid = 1'b0;
            w_addr  = r_addr + ADDR_W'(1);
            if (w_last_byte) begin
              w_csn   = 1'b1;
              w_done  = 1'b1;
              w_state = S_DONE;
            end else begin
              w_sck   = 1'b1;
              w_rx    = {r_rx[6:0], flash_miso};
              w_cnt   = 5'd1;
              w_state = S_DATA;
            end
          end
        end
        S_DONE: begin
          w_csn = 1'b1;
          w_sck = 1'b0;
        end
        default: begin
          w_state = S_GAP;
          w_csn   = 1'b1;
          w_sck   = 1'b0;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_GAP;
      r_csn   <= 1'b1;
      r_sck   <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_index <= '0;
      r_len   <= DEF_LEN;
    end else begin
      r_state <= w_state;
      r_csn   <= w_csn;
      r_sck   <= w_sck;
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_index <= w_index;
      r_len   <= w_len;
    end
  end

  assign flash_csn       = r_csn;
  assign flash_sck       = r_sck;
  assign flash_mosi      = r_tx[31];
  assign load_addr       = r_addr;
  assign load_write_data = r_wdata;
  assign data_valid      = r_valid;
  assign load_done       = r_done;
  assign busy            = (r_state != S_DONE);

endmodule
